// File: rtl/mutex_arbiter.sv
// mutex_arbiter: N-way round-robin mutual-exclusion arbiter with registered one-hot grant.
// Optional forced revoke after HOLD_MAX grant cycles: define MUTEX_ARB_TIMEOUT_EN.
module mutex_arbiter #(
  parameter int  N        = 4,
  parameter int  HOLD_MAX = 255,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t        state_reg;
  logic [N-1:0]  gnt_reg;
  logic [IW-1:0] gnt_id_reg;
  logic          busy_reg;
  logic [IW-1:0] ptr_reg;

  logic [N-1:0]  block;
  logic [N-1:0]  elig;
  logic [N-1:0]  sel_onehot;
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] ptr_next;
  logic          owner_req;
  logic          revoke;

  if (N < 2 || N > 16 || HOLD_MAX < 1) begin : g_param_err
    $error("mutex_arbiter: N must be 2..16 and HOLD_MAX at least 1");
  end

`ifdef MUTEX_ARB_TIMEOUT_EN
  localparam int CW = (HOLD_MAX > 255) ? 16 : 8;

  logic [CW-1:0] hold_cnt_reg;
  logic [N-1:0]  block_reg;
  logic          timeout_err_reg;

  // A release on the final allowed cycle wins over the revoke.
  assign revoke      = (state_reg == GRANT) && owner_req &&
                       (hold_cnt_reg == CW'(HOLD_MAX - 1));
  assign block       = block_reg;
  assign timeout_err = timeout_err_reg;
`else
  assign revoke      = 1'b0;
  assign block       = '0;
  assign timeout_err = 1'b0;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign elig[gi]       = req[gi] & ~block[gi];
    assign sel_onehot[gi] = (sel_idx == IW'(gi));
  end

  // Scan from ptr upward with wrap; walking backwards lets the nearest eligible index win.
  always_comb begin : sel_scan
    int j;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_reg) + k;
      if (j >= N) j = j - N;
      if (elig[IW'(j)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(j);
      end
    end
  end

  assign ptr_next  = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + 1'b1;
  assign owner_req = req[gnt_id_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      gnt_id_reg      <= '0;
      busy_reg        <= 1'b0;
      ptr_reg         <= '0;
`ifdef MUTEX_ARB_TIMEOUT_EN
      hold_cnt_reg    <= '0;
      block_reg       <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
`ifdef MUTEX_ARB_TIMEOUT_EN
      timeout_err_reg <= revoke;
      // A blocked requester becomes eligible again once it has been seen low.
      block_reg       <= (block_reg & req) | (revoke ? gnt_reg : '0);
      hold_cnt_reg    <= (state_reg == GRANT) ? hold_cnt_reg + 1'b1 : '0;
`endif
      case (state_reg)
        GRANT: begin
          if (!owner_req || revoke) begin
            state_reg  <= RELEASE;
            gnt_reg    <= '0;
            gnt_id_reg <= '0;
            busy_reg   <= 1'b0;
          end
        end
        default: begin
          if (sel_found) begin
            state_reg  <= GRANT;
            gnt_reg    <= sel_onehot;
            gnt_id_reg <= sel_idx;
            busy_reg   <= 1'b1;
            ptr_reg    <= ptr_next;
          end else begin
            state_reg  <= IDLE;
          end
        end
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_mutex_arbiter.sv
// Scoreboard bench for mutex_arbiter (N=4, HOLD_MAX=8); covers the timeout path when
// MUTEX_ARB_TIMEOUT_EN is defined and the unbounded-grant path otherwise.
module tb_mutex_arbiter;

  localparam int N  = 4;
  localparam int HM = 8;
`ifdef MUTEX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout_err;

  mutex_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: owner -1 means nobody holds the resource.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_cnt   = 0;
  logic [3:0] m_block = '0;
  bit         m_to    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_block = '0;
    m_to    = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model by one sampling edge with request vector r and queue the outputs it implies.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] blk;
    int         w;
    exp_t       e;
    blk  = m_block & r;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (TO_EN && m_cnt == HM - 1) begin
        blk[m_owner] = 1'b1;
        m_owner      = -1;
        m_to         = 1'b1;
      end else begin
        m_cnt++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        w = (m_ptr + k) % N;
        if (m_owner < 0 && r[w] && !m_block[w]) begin
          m_owner = w;
          m_ptr   = (w + 1) % N;
          m_cnt   = 0;
        end
      end
    end
    m_block = blk;
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.busy  = (m_owner >= 0);
    e.to    = m_to;
    exp_q.push_back(e);
  endtask

  // Drive r for one clock, then compare the registered outputs against the scoreboard.
  task automatic cyc(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(r);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt", gnt, e.gnt);
      check("gnt_id", gnt_id, e.id);
      check("busy", busy, e.busy);
      check("timeout_err", timeout_err, e.to);
    end
    check("onehot0", $onehot0(gnt), 1);
    check("gnt_without_req", |(gnt & ~r), 0);
    check("busy_vs_gnt", busy, |gnt);
    check("id_match", busy ? (gnt == (4'b0001 << gnt_id)) : (gnt_id == 2'd0), 1);
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    int         hold;
    int         guard;
    bit         to_seen;

    #2;
    do_reset();

    // 1: single requester, grant then release
    cyc(4'b0001);
    check("t1_gnt", gnt, 4'b0001);
    cyc(4'b0000);
    check("t1_release", busy, 0);
    cyc(4'b0000);

    // 2: full contention, each owner holds 3 cycles, one dead cycle between owners
    do_reset();
    r = 4'b1111;
    cyc(r);
    for (int k = 0; k < 4; k++) begin
      check("t2_owner", gnt, 4'b0001 << k);
      cyc(r);
      cyc(r);
      r[k] = 1'b0;
      cyc(r);
      check("t2_dead", gnt, 0);
      if (k < 3) cyc(r);
    end
    cyc(4'b0000);

    // 3: late arrival granted only after the owner's turnaround; ptr wraps to 0
    cyc(4'b0010);
    check("t3_owner1", gnt, 4'b0010);
    cyc(4'b1010);
    check("t3_hold1", gnt, 4'b0010);
    cyc(4'b1000);
    check("t3_dead", gnt, 0);
    cyc(4'b1000);
    check("t3_owner3", gnt, 4'b1000);
    cyc(4'b0000);
    cyc(4'b0101);
    check("t3_wrap_0_wins", gnt, 4'b0001);
    cyc(4'b0000);
    cyc(4'b0000);

    // 4: asynchronous reset mid-grant; 3 would win over 0 if ptr were not cleared
    cyc(4'b0100);
    check("t4_owner2", gnt, 4'b0100);
    #3;
    do_reset();
    cyc(4'b1001);
    check("t4_ptr_reset", gnt, 4'b0001);
    cyc(4'b0000);
    cyc(4'b0000);

    do_reset();
    to_seen = 1'b0;
    if (TO_EN) begin
      // 5: forced revoke after HM cycles, then block until req[0] toggles
      cyc(4'b0011);
      hold  = 0;
      guard = 0;
      while (gnt[0] && guard < 40) begin
        hold++;
        guard++;
        cyc(4'b0011);
      end
      check("t5_hold_len", hold, HM);
      check("t5_timeout_pulse", timeout_err, 1);
      check("t5_dead", gnt, 0);
      cyc(4'b0011);
      check("t5_next_owner", gnt, 4'b0010);
      check("t5_pulse_once", timeout_err, 0);
      cyc(4'b0011);
      cyc(4'b0001);
      for (int k = 0; k < 4; k++) begin
        cyc(4'b0001);
        check("t5_blocked", gnt, 0);
      end
      cyc(4'b0000);
      cyc(4'b0001);
      check("t5_regrant", gnt, 4'b0001);
      cyc(4'b0000);
    end else begin
      // 6: unbounded grant without the timeout feature
      hold = 0;
      for (int k = 0; k < 1000; k++) begin
        cyc(4'b0001);
        if (gnt == 4'b0001) hold++;
        to_seen |= timeout_err;
      end
      check("t6_held_all", hold, 1000);
      check("t6_no_timeout", to_seen, 0);
      cyc(4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
